pipe_bundle_skid: RTL and testbench
===================================

PIPE_BUNDLE_SKID -- requirements
Module: pipe_bundle_skid

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, PC and branch-target width.
REQ-002 Parameter ISN_WIDTH, default 99, decoded-instruction width per lane.
REQ-003 Parameter LANES, default 4, instruction slots per bundle (1..8).
REQ-004 Parameter THREAD_BITS, default 2, thread-ID width.
REQ-005 i_Clk  in  1  clock; all state updates on rising edge.
REQ-006 i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 i_Flush  in  1  global flush, discards all held and incoming bundles.
REQ-008 i_Flush_thread_en  in  1  selective flush enable.
REQ-009 i_Flush_thread  in  THREAD_BITS  thread ID to discard when i_Flush_thread_en=1.
REQ-010 i_valid  in  1  upstream bundle valid.
REQ-011 o_ready  out  1  upstream may transfer; transfer = i_valid & o_ready.
REQ-012 i_PC, i_branch_target  in  ADDRESS_WIDTH each  bundle PC and predicted target.
REQ-013 i_Instructions  in  LANES*ISN_WIDTH  lane k at bits [k*ISN_WIDTH +: ISN_WIDTH].
REQ-014 i_lane_valid  in  LANES  per-lane valid; i_prediction in 1; i_thread in THREAD_BITS.
REQ-015 o_valid  out  1  downstream bundle valid; i_ready in 1, downstream accept; consume = o_valid & i_ready.
REQ-016 o_PC, o_branch_target, o_Instructions, o_lane_valid, o_prediction, o_thread  out  widths mirror inputs  head-bundle payload.
REQ-017 o_occupancy  out  2  held bundles (0..2).

Function
REQ-018 Two-entry in-order buffer: HEAD (drives outputs) and SKID; states EMPTY (0), ONE (HEAD valid), FULL (both valid).
REQ-019 o_ready = !SKID valid, driven from state registers only (no combinational path from i_ready).
REQ-020 Transfer in EMPTY loads HEAD; o_valid=1 next cycle (latency 1).
REQ-021 Transfer in ONE with consume loads HEAD (state stays ONE); without consume loads SKID (-> FULL).
REQ-022 FULL with consume: SKID moves to HEAD (-> ONE), o_ready=1 next cycle; FULL without consume: hold all.
REQ-023 ONE with consume and no transfer -> EMPTY.
REQ-024 A transfer with i_lane_valid=0 is accepted (handshake completes) but not stored.
REQ-025 HEAD payload SHALL be stable while o_valid=1 and i_ready=0.
REQ-026 i_Flush=1: both entries invalidated, incoming transfer discarded, -> EMPTY next cycle; overrides every other input.
REQ-027 i_Flush_thread_en=1 (no i_Flush): entries and the incoming transfer whose thread equals i_Flush_thread are discarded; a surviving SKID shifts to HEAD the same edge; surviving order preserved.
REQ-028 Consume of a HEAD that is simultaneously thread-flushed is still counted as consumed (no double effect).
REQ-029 Invalidated entries SHALL zero their payload registers; o_PC, o_Instructions etc. read 0 when o_valid=0.
REQ-030 o_occupancy equals count of valid entries after each edge.

Reset
REQ-031 While i_Reset_n=0: all payload outputs 0, o_valid=0, o_occupancy=0, o_ready=1, state EMPTY, stats counter 0; asynchronous, immediate.
REQ-032 Reset mid-transfer discards all bundles; first transfer after release is accepted normally.

Configuration
REQ-033 Macro PIPE_BUNDLE_SKID_STATS_EN defined: add output o_stall_cycles (16 bits), incremented each cycle o_valid=1 and i_ready=0, saturating at 16'hFFFF, cleared by reset and by i_Flush.
REQ-034 Macro undefined: o_stall_cycles port and counter absent; all other behaviour identical.

Verification
REQ-035 Reset release, i_ready=1, one bundle PC=0x100 thread=1 lanes=4'b1111 -> o_valid=1 next cycle, o_PC=0x100, o_occupancy=1, then 0.
REQ-036 i_ready=0, transfers PC=0x100, 0x104 -> o_occupancy=2, o_ready=0; i_ready=1 -> outputs 0x100 then 0x104 in order, o_ready=1 after first consume.
REQ-037 FULL with HEAD thread=2, SKID thread=1, flush thread 2 -> next cycle HEAD=SKID bundle (thread 1), o_occupancy=1.
REQ-038 FULL plus i_Flush=1 with simultaneous transfer PC=0x200 -> EMPTY, o_valid=0, all payloads 0, o_ready=1.
REQ-039 Transfer with i_lane_valid=4'b0000 -> o_ready stays 1, o_valid stays 0.
REQ-040 STATS_EN: hold o_valid=1, i_ready=0 for 70000 cycles -> o_stall_cycles=16'hFFFF; i_Flush -> 0.

Source files
------------

// File: rtl/pipe_bundle_skid.sv
// pipe_bundle_skid: two-entry in-order skid buffer for decoded instruction
// bundles (HEAD drives the outputs, SKID catches a bundle when downstream
// stalls). It supports a global flush, a per-thread selective flush, and
// dropping bundles that have no valid lanes.
// Optional build macro PIPE_BUNDLE_SKID_STATS_EN adds the o_stall_cycles
// counter port.
module pipe_bundle_skid #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ISN_WIDTH     = 99,
  parameter int LANES         = 4,
  parameter int THREAD_BITS   = 2
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset_n,
  input  logic                           i_Flush,
  input  logic                           i_Flush_thread_en,
  input  logic [THREAD_BITS-1:0]         i_Flush_thread,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [ADDRESS_WIDTH-1:0]       i_PC,
  input  logic [ADDRESS_WIDTH-1:0]       i_branch_target,
  input  logic [LANES*ISN_WIDTH-1:0]     i_Instructions,
  input  logic [LANES-1:0]               i_lane_valid,
  input  logic                           i_prediction,
  input  logic [THREAD_BITS-1:0]         i_thread,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [ADDRESS_WIDTH-1:0]       o_PC,
  output logic [ADDRESS_WIDTH-1:0]       o_branch_target,
  output logic [LANES*ISN_WIDTH-1:0]     o_Instructions,
  output logic [LANES-1:0]               o_lane_valid,
  output logic                           o_prediction,
  output logic [THREAD_BITS-1:0]         o_thread,
  output logic [1:0]                     o_occupancy
`ifdef PIPE_BUNDLE_SKID_STATS_EN
  ,
  output logic [15:0]                    o_stall_cycles
`endif
);

  // Buffer occupancy states; SKID is only ever valid when HEAD is valid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]   pc;
    logic [ADDRESS_WIDTH-1:0]   target;
    logic [LANES*ISN_WIDTH-1:0] insns;
    logic [LANES-1:0]           lanes;
    logic                       pred;
    logic [THREAD_BITS-1:0]     thread;
  } bundle_t;

  logic [1:0] state_reg, state_next;
  bundle_t    head_reg, head_next;
  bundle_t    skid_reg, skid_next;
  bundle_t    in_bundle;

  logic head_valid, skid_valid;
  logic transfer, consume;
  logic head_hit, skid_hit, in_hit;
  logic head_keep, skid_keep, in_keep;

  assign head_valid = (state_reg != ST_EMPTY);
  assign skid_valid = (state_reg == ST_FULL);

  assign in_bundle = '{pc:     i_PC,
                       target: i_branch_target,
                       insns:  i_Instructions,
                       lanes:  i_lane_valid,
                       pred:   i_prediction,
                       thread: i_thread};

  // Ready depends only on registered state, so i_ready never reaches o_ready.
  assign o_ready  = !skid_valid;
  assign transfer = i_valid && o_ready;
  assign consume  = head_valid && i_ready;

  assign head_hit = i_Flush_thread_en && (head_reg.thread == i_Flush_thread);
  assign skid_hit = i_Flush_thread_en && (skid_reg.thread == i_Flush_thread);
  assign in_hit   = i_Flush_thread_en && (i_thread == i_Flush_thread);

  // A consumed HEAD leaves exactly once, whether or not it is also flushed.
  assign head_keep = head_valid && !consume && !head_hit;
  assign skid_keep = skid_valid && !skid_hit;
  // Empty-lane bundles complete the handshake but are never stored.
  assign in_keep   = transfer && (|i_lane_valid) && !in_hit;

  // Compact the survivors (HEAD, SKID, incoming) in order into HEAD then SKID.
  // The incoming bundle can only arrive when SKID is empty, so at most two survive.
  always_comb begin
    head_next  = '0;
    skid_next  = '0;
    state_next = ST_EMPTY;
    if (!i_Flush) begin
      if (head_keep) begin
        head_next = head_reg;
        if (skid_keep) begin
          skid_next  = skid_reg;
          state_next = ST_FULL;
        end else if (in_keep) begin
          skid_next  = in_bundle;
          state_next = ST_FULL;
        end else begin
          state_next = ST_ONE;
        end
      end else if (skid_keep) begin
        head_next = skid_reg;
        if (in_keep) begin
          skid_next  = in_bundle;
          state_next = ST_FULL;
        end else begin
          state_next = ST_ONE;
        end
      end else if (in_keep) begin
        head_next  = in_bundle;
        state_next = ST_ONE;
      end
    end
  end

  // State and payload registers; invalid entries always hold zero.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg <= ST_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      skid_reg  <= skid_next;
    end
  end

  assign o_valid         = head_valid;
  assign o_PC            = head_reg.pc;
  assign o_branch_target = head_reg.target;
  assign o_Instructions  = head_reg.insns;
  assign o_lane_valid    = head_reg.lanes;
  assign o_prediction    = head_reg.pred;
  assign o_thread        = head_reg.thread;
  assign o_occupancy     = {1'b0, head_valid} + {1'b0, skid_valid};

`ifdef PIPE_BUNDLE_SKID_STATS_EN
  logic [15:0] stall_reg;

  // Count cycles where a bundle is offered but downstream refuses it; saturates.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      stall_reg <= '0;
    end else if (i_Flush) begin
      stall_reg <= '0;
    end else if (head_valid && !i_ready && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign o_stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_pipe_bundle_skid.sv
// tb_pipe_bundle_skid: directed scenarios followed by randomized traffic,
// checked against a queue-based model of the bundle buffer.
// The stall-counter scenario is built only with PIPE_BUNDLE_SKID_STATS_EN.
module tb_pipe_bundle_skid;
  localparam int AW = 32;
  localparam int IW = 99;
  localparam int L  = 4;
  localparam int TB = 2;

  logic                i_Clk;
  logic                i_Reset_n;
  logic                i_Flush;
  logic                i_Flush_thread_en;
  logic [TB-1:0]       i_Flush_thread;
  logic                i_valid;
  logic                o_ready;
  logic [AW-1:0]       i_PC;
  logic [AW-1:0]       i_branch_target;
  logic [L*IW-1:0]     i_Instructions;
  logic [L-1:0]        i_lane_valid;
  logic                i_prediction;
  logic [TB-1:0]       i_thread;
  logic                o_valid;
  logic                i_ready;
  logic [AW-1:0]       o_PC;
  logic [AW-1:0]       o_branch_target;
  logic [L*IW-1:0]     o_Instructions;
  logic [L-1:0]        o_lane_valid;
  logic                o_prediction;
  logic [TB-1:0]       o_thread;
  logic [1:0]          o_occupancy;
`ifdef PIPE_BUNDLE_SKID_STATS_EN
  logic [15:0]         o_stall_cycles;
`endif

  pipe_bundle_skid #(
    .ADDRESS_WIDTH(AW), .ISN_WIDTH(IW), .LANES(L), .THREAD_BITS(TB)
  ) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Flush(i_Flush),
    .i_Flush_thread_en(i_Flush_thread_en), .i_Flush_thread(i_Flush_thread),
    .i_valid(i_valid), .o_ready(o_ready), .i_PC(i_PC),
    .i_branch_target(i_branch_target), .i_Instructions(i_Instructions),
    .i_lane_valid(i_lane_valid), .i_prediction(i_prediction), .i_thread(i_thread),
    .o_valid(o_valid), .i_ready(i_ready), .o_PC(o_PC),
    .o_branch_target(o_branch_target), .o_Instructions(o_Instructions),
    .o_lane_valid(o_lane_valid), .o_prediction(o_prediction), .o_thread(o_thread),
    .o_occupancy(o_occupancy)
`ifdef PIPE_BUNDLE_SKID_STATS_EN
    , .o_stall_cycles(o_stall_cycles)
`endif
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [AW-1:0]   target;
    logic [L*IW-1:0] insns;
    logic [L-1:0]    lanes;
    logic            pred;
    logic [TB-1:0]   thread;
  } bun_t;

  // Reference model: ordered list of held bundles plus the expected stall count.
  bun_t q[$];
  int   stall_m = 0;
  int   total   = 0;
  int   passed  = 0;
  int   failed  = 0;
  bit   verbose = 1'b1;
  int   step_no = 0;

  function automatic bun_t in_b();
    return {i_PC, i_branch_target, i_Instructions, i_lane_valid, i_prediction, i_thread};
  endfunction

  function automatic bun_t dut_b();
    return {o_PC, o_branch_target, o_Instructions, o_lane_valid, o_prediction, o_thread};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bun_t exp_b;
    exp_b = (q.size() > 0) ? q[0] : '0;
    chk("o_valid", o_valid, (q.size() > 0));
    chk("o_ready", o_ready, (q.size() < 2));
    chk("o_occupancy", o_occupancy, q.size());
    chk("payload", dut_b(), exp_b);
`ifdef PIPE_BUNDLE_SKID_STATS_EN
    chk("o_stall_cycles", o_stall_cycles, stall_m);
`endif
  endtask

  // Apply one clock edge's worth of buffer rules to the model.
  task automatic model_edge();
    int  n;
    bit  xfer;
    n    = q.size();
    xfer = i_valid && (n < 2);
    if (i_Flush) stall_m = 0;
    else if (n > 0 && !i_ready && stall_m < 65535) stall_m++;
    if (i_Flush) begin
      q.delete();
    end else begin
      if (i_ready && n > 0) q.delete(0);
      if (i_Flush_thread_en)
        for (int k = q.size() - 1; k >= 0; k--)
          if (q[k].thread == i_Flush_thread) q.delete(k);
      if (xfer && i_lane_valid != '0 && !(i_Flush_thread_en && i_thread == i_Flush_thread))
        q.push_back(in_b());
    end
  endtask

  // Check current outputs, advance model and DUT by one cycle; returns on negedge.
  task automatic step();
    step_no++;
    if (verbose)
      $display("step %0d: valid_in=%0b pc_in=%0h thr_in=%0d ready_in=%0b flush=%0b tflush=%0b/%0d -> o_valid=%0b o_PC=%0h occ=%0d",
               step_no, i_valid, i_PC, i_thread, i_ready, i_Flush, i_Flush_thread_en,
               i_Flush_thread, o_valid, o_PC, o_occupancy);
    check_outputs();
    model_edge();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  task automatic set_bundle(input logic [AW-1:0] pc, input logic [TB-1:0] thr, input logic [L-1:0] lanes);
    i_valid         = 1'b1;
    i_PC            = pc;
    i_branch_target = pc ^ 32'h0000_5A00;
    for (int w = 0; w < L * IW; w += 32)
      for (int b = 0; b < 32 && (w + b) < L * IW; b++)
        i_Instructions[w + b] = 1'($urandom_range(0, 1));
    i_lane_valid    = lanes;
    i_prediction    = 1'($urandom_range(0, 1));
    i_thread        = thr;
  endtask

  initial begin
    i_Reset_n = 1'b0; i_Flush = 1'b0; i_Flush_thread_en = 1'b0; i_Flush_thread = '0;
    i_valid = 1'b0; i_PC = '0; i_branch_target = '0; i_Instructions = '0;
    i_lane_valid = '0; i_prediction = 1'b0; i_thread = '0; i_ready = 1'b1;

    // Reset state
    #1;
    check_outputs();
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Reset_n = 1'b1;

    // Single bundle passes through with latency 1
    set_bundle(32'h100, 2'd1, 4'b1111);
    step();
    i_valid = 1'b0;
    chk("r035_pc", o_PC, 32'h100);
    chk("r035_occ", o_occupancy, 2'd1);
    step();
    chk("r035_empty", o_occupancy, 2'd0);

    // Stall fills SKID, then drain in order
    i_ready = 1'b0;
    set_bundle(32'h100, 2'd0, 4'b1111);
    step();
    set_bundle(32'h104, 2'd0, 4'b0011);
    step();
    i_valid = 1'b0;
    chk("r036_occ", o_occupancy, 2'd2);
    chk("r036_ready", o_ready, 1'b0);
    step();
    i_ready = 1'b1;
    step();
    chk("r036_second_pc", o_PC, 32'h104);
    chk("r036_ready_after", o_ready, 1'b1);
    step();
    step();

    // Thread flush of HEAD promotes SKID
    i_ready = 1'b0;
    set_bundle(32'h300, 2'd2, 4'b1111);
    step();
    set_bundle(32'h304, 2'd1, 4'b0101);
    step();
    i_valid = 1'b0;
    i_Flush_thread_en = 1'b1; i_Flush_thread = 2'd2;
    step();
    i_Flush_thread_en = 1'b0;
    chk("r037_pc", o_PC, 32'h304);
    chk("r037_thread", o_thread, 2'd1);
    chk("r037_occ", o_occupancy, 2'd1);

    // Global flush from FULL with an incoming bundle
    set_bundle(32'h308, 2'd0, 4'b1000);
    step();
    i_Flush = 1'b1;
    set_bundle(32'h200, 2'd3, 4'b1111);
    step();
    i_Flush = 1'b0; i_valid = 1'b0;
    chk("r038_valid", o_valid, 1'b0);
    chk("r038_pc", o_PC, 32'h0);
    chk("r038_ready", o_ready, 1'b1);
    // Global flush discards a transfer into an empty buffer
    i_Flush = 1'b1;
    set_bundle(32'h204, 2'd0, 4'b1111);
    step();
    i_Flush = 1'b0; i_valid = 1'b0;
    step();

    // Empty-lane bundle is accepted but dropped
    i_ready = 1'b1;
    set_bundle(32'h400, 2'd0, 4'b0000);
    step();
    i_valid = 1'b0;
    chk("r039_ready", o_ready, 1'b1);
    chk("r039_valid", o_valid, 1'b0);
    step();

    // Randomized traffic
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      set_bundle($urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      i_valid           = 1'($urandom_range(0, 1));
      i_ready           = ($urandom_range(0, 2) != 0);
      i_Flush           = ($urandom_range(0, 39) == 0);
      i_Flush_thread_en = ($urandom_range(0, 7) == 0);
      i_Flush_thread    = 2'($urandom_range(0, 3));
      step();
    end
    i_Flush = 1'b0; i_Flush_thread_en = 1'b0;
    verbose = 1'b1;

    // Asynchronous reset in the middle of traffic
    i_ready = 1'b0;
    set_bundle(32'h500, 2'd1, 4'b1111);
    step();
    set_bundle(32'h504, 2'd1, 4'b1111);
    i_Reset_n = 1'b0;
    #1;
    q.delete();
    stall_m = 0;
    check_outputs();
    @(negedge i_Clk);
    i_Reset_n = 1'b1;
    i_ready = 1'b1;
    set_bundle(32'h600, 2'd3, 4'b0001);
    step();
    i_valid = 1'b0;
    chk("reset_recover_pc", o_PC, 32'h600);
    step();

`ifdef PIPE_BUNDLE_SKID_STATS_EN
    // Stall counter saturation and clear by flush
    verbose = 1'b0;
    i_ready = 1'b0;
    set_bundle(32'h700, 2'd0, 4'b1111);
    step();
    i_valid = 1'b0;
    for (int c = 0; c < 70000; c++) step();
    chk("stall_sat", o_stall_cycles, 16'hFFFF);
    i_Flush = 1'b1;
    step();
    i_Flush = 1'b0;
    chk("stall_clear", o_stall_cycles, 16'h0000);
    verbose = 1'b1;
`endif

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard bound in case the clock or a wait never progresses.
  initial begin
    #20_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
